guess_game_ctrl: RTL and testbench

//  Sequencer for the switch-entry guessing game on the DE1-SoC top level.
//  - Draws a secret value from an on-chip LFSR and accepts one guess per key press.
//  - Reports too-high / too-low / win, counts remaining tries, declares a loss at zero tries.
//  - Sits between the debounced/inverted KEY and SW inputs and the LEDR/HEX display logic.

---
 rtl/guess_game_pkg.sv | 26 ++
 rtl/guess_game_ctrl_lfsr8.sv | 44 ++++
 rtl/guess_game_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
// -----------------------------------------------------------------------------
// guess_game_pkg
//   Shared types and helpers for the switch-entry guessing game sequencer.
//   - state_t    : game FSM states
//   - LFSR_TAPS  : feedback tap mask for the 8-bit Fibonacci LFSR
//                  (x^8 + x^6 + x^5 + x^4 + 1 -> bits 7,5,4,3)
//   - lfsr_next(): one shift step of that LFSR
// -----------------------------------------------------------------------------
package guess_game_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PLAY  = 3'd1,
      CHECK = 3'd2,
      WON   = 3'd3,
      LOST  = 3'd4
   } state_t;

   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Shift left, feeding the XOR of the tapped bits into bit 0.
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage : guess_game_pkg

// File: rtl/guess_game_ctrl_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
//   Free-running 8-bit Fibonacci LFSR used as the secret source.
//   Ports:
//     clk   in   1  rising-edge clock
//     reset in   1  synchronous, active-high; loads seed
//     seed  in   8  value loaded during reset (must be nonzero)
//     q     out  8  current LFSR state
// -----------------------------------------------------------------------------
module lfsr8
   import guess_game_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_next(lfsr_q);
      // A maximal-length sequence from a nonzero state never reaches 0; this
      // guard only matters if the register were ever upset into the lock-up
      // state, and pulls it back into the sequence.
      if (lfsr_d == 8'h00) begin
         lfsr_d = 8'h01;
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q <= seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q = lfsr_q;

endmodule : lfsr8

// File: rtl/guess_game_ctrl.sv
// -----------------------------------------------------------------------------
// guess_game_ctrl
//   Sequencer for the switch-entry guessing game. Draws a secret from an LFSR
//   at each game start, takes one guess per submit press, reports too-high /
//   too-low / win, counts remaining tries and declares a loss at zero tries.
//   Ports:
//     clk        in   1      rising-edge clock
//     reset      in   1      synchronous, active-high; clears all state
//     start      in   1      rising edge starts/restarts a game
//     submit     in   1      rising edge enters the current guess
//     guess      in   WIDTH  player value (unsigned)
//     force_en   in   1      at a start edge, use force_val as the secret
//     force_val  in   WIDTH  forced secret
//     too_high   out  1      last guess > secret
//     too_low    out  1      last guess < secret
//     win        out  1      game won (held until start/reset)
//     lose       out  1      tries exhausted (held until start/reset)
//     tries_left out  TW     remaining guesses, TW = $clog2(MAX_TRIES+1)
//     secret_o   out  WIDTH  secret while win|lose, else 0
// -----------------------------------------------------------------------------
module guess_game_ctrl
   import guess_game_pkg::*;
#(
   parameter int         WIDTH     = 3,
   parameter int         MAX_TRIES = 4,
   parameter logic [7:0] SEED      = 8'hA5
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic                               submit,
   input  logic [WIDTH-1:0]                   guess,
   input  logic                               force_en,
   input  logic [WIDTH-1:0]                   force_val,
   output logic                               too_high,
   output logic                               too_low,
   output logic                               win,
   output logic                               lose,
   output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
   output logic [WIDTH-1:0]                   secret_o
);

   localparam int            TW         = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0] TRIES_INIT = TW'(MAX_TRIES);

   // ---------------------------------------------------------------------------
   // Input sample stage and edge detection.
   // Inputs are captured once (x_s_q) and again (x_q); an edge is x_s_q & ~x_q.
   // A submit first sampled at edge N is therefore acted on at N+1 (CHECK) and
   // its result is registered at N+2. guess/force_* travel with the same stage
   // so the values paired with an edge are the ones present when it was seen.
   // ---------------------------------------------------------------------------
   logic             start_s_q;
   logic             start_q;
   logic             submit_s_q;
   logic             submit_q;
   logic [WIDTH-1:0] guess_s_q;
   logic             force_en_s_q;
   logic [WIDTH-1:0] force_val_s_q;

   logic start_edge;
   logic submit_edge;

   always_ff @(posedge clk) begin
      if (reset) begin
         start_s_q     <= 1'b0;
         start_q       <= 1'b0;
         submit_s_q    <= 1'b0;
         submit_q      <= 1'b0;
         guess_s_q     <= '0;
         force_en_s_q  <= 1'b0;
         force_val_s_q <= '0;
      end else begin
         start_s_q     <= start;
         start_q       <= start_s_q;
         submit_s_q    <= submit;
         submit_q      <= submit_s_q;
         guess_s_q     <= guess;
         force_en_s_q  <= force_en;
         force_val_s_q <= force_val;
      end
   end

   assign start_edge  = start_s_q  & ~start_q;
   assign submit_edge = submit_s_q & ~submit_q;

   // ---------------------------------------------------------------------------
   // Secret source
   // ---------------------------------------------------------------------------
   logic [7:0] lfsr;

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (SEED),
      .q     (lfsr)
   );

   // Only the low WIDTH bits form the secret; the rest are deliberately unused.
   generate
      if (WIDTH < 8) begin : g_lfsr_hi
         logic unused_lfsr_hi;
         assign unused_lfsr_hi = ^lfsr[7:WIDTH];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Game FSM and registered outputs
   // ---------------------------------------------------------------------------
   state_t           state_q,    state_d;
   logic [WIDTH-1:0] secret_q,   secret_d;
   logic [WIDTH-1:0] guess_q,    guess_d;
   logic [TW-1:0]    tries_q,    tries_d;
   logic             too_high_q, too_high_d;
   logic             too_low_q,  too_low_d;
   logic             win_q,      win_d;
   logic             lose_q,     lose_d;
   logic [WIDTH-1:0] secret_o_q, secret_o_d;

   logic [TW-1:0]    tries_dec;

   // Saturating decrement so tries_left can never wrap.
   assign tries_dec = (tries_q != '0) ? (tries_q - TW'(1)) : '0;

   always_comb begin
      // NOTE: every signal assigned here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_d    = state_q;
      secret_d   = secret_q;
      guess_d    = guess_q;
      tries_d    = tries_q;
      too_high_d = too_high_q;
      too_low_d  = too_low_q;
      win_d      = win_q;
      lose_d     = lose_q;
      secret_o_d = secret_o_q;

      if (start_edge) begin
         // Start wins over everything, including a pending CHECK and a
         // simultaneous submit edge.
         state_d    = PLAY;
         secret_d   = force_en_s_q ? force_val_s_q : lfsr[WIDTH-1:0];
         tries_d    = TRIES_INIT;
         too_high_d = 1'b0;
         too_low_d  = 1'b0;
         win_d      = 1'b0;
         lose_d     = 1'b0;
         secret_o_d = '0;
      end else begin
         unique case (state_q)
            PLAY: begin
               if (submit_edge) begin
                  state_d = CHECK;
                  guess_d = guess_s_q;
               end
            end

            CHECK: begin
               if (guess_q == secret_q) begin
                  state_d    = WON;
                  win_d      = 1'b1;
                  too_high_d = 1'b0;
                  too_low_d  = 1'b0;
                  secret_o_d = secret_q;
               end else begin
                  tries_d    = tries_dec;
                  too_high_d = (guess_q > secret_q);
                  too_low_d  = (guess_q < secret_q);
                  if (tries_dec == '0) begin
                     state_d    = LOST;
                     lose_d     = 1'b1;
                     secret_o_d = secret_q;
                  end else begin
                     state_d = PLAY;
                  end
               end
            end

            IDLE, WON, LOST: begin
               // Submits are ignored; only a start edge leaves these states.
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         secret_q   <= '0;
         guess_q    <= '0;
         tries_q    <= '0;
         too_high_q <= 1'b0;
         too_low_q  <= 1'b0;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
         secret_o_q <= '0;
      end else begin
         state_q    <= state_d;
         secret_q   <= secret_d;
         guess_q    <= guess_d;
         tries_q    <= tries_d;
         too_high_q <= too_high_d;
         too_low_q  <= too_low_d;
         win_q      <= win_d;
         lose_q     <= lose_d;
         secret_o_q <= secret_o_d;
      end
   end

   assign too_high   = too_high_q;
   assign too_low    = too_low_q;
   assign win        = win_q;
   assign lose       = lose_q;
   assign tries_left = tries_q;
   assign secret_o   = secret_o_q;

endmodule : guess_game_ctrl

// File: tb/tb_guess_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_guess_game_ctrl
//   Directed bench for guess_game_ctrl (WIDTH=3, MAX_TRIES=4, SEED=8'hA5).
//   A small game model computes expected outputs; each expectation is queued
//   when stimulus is driven and popped when the DUT result is due.
// -----------------------------------------------------------------------------
module tb_guess_game_ctrl;
   import guess_game_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       submit;
   logic [2:0] guess;
   logic       force_en;
   logic [2:0] force_val;
   logic       too_high;
   logic       too_low;
   logic       win;
   logic       lose;
   logic [2:0] tries_left;
   logic [2:0] secret_o;

   guess_game_ctrl #(
      .WIDTH     (3),
      .MAX_TRIES (4),
      .SEED      (8'hA5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .submit     (submit),
      .guess      (guess),
      .force_en   (force_en),
      .force_val  (force_val),
      .too_high   (too_high),
      .too_low    (too_low),
      .win        (win),
      .lose       (lose),
      .tries_left (tries_left),
      .secret_o   (secret_o)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference LFSR: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] ref_lfsr_step(input logic [7:0] s);
      logic fb;
      fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      return {s[6:0], fb};
   endfunction

   logic [7:0] m_lfsr;
   always @(posedge clk) begin
      if (reset) m_lfsr <= 8'hA5;
      else       m_lfsr <= ref_lfsr_step(m_lfsr);
   end

   // ---------------------------------------------------------------------------
   // Game model and scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      logic       th;
      logic       tl;
      logic       w;
      logic       l;
      logic [2:0] tries;
      logic [2:0] sec;
   } res_t;

   res_t sb[$];

   logic       m_play;
   logic       m_th, m_tl, m_win, m_lose;
   logic [2:0] m_tries, m_secret, m_seco;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_play = 1'b0; m_th = 1'b0; m_tl = 1'b0; m_win = 1'b0; m_lose = 1'b0;
      m_tries = 3'd0; m_secret = 3'd0; m_seco = 3'd0;
   endtask

   task automatic push_expect();
      res_t r;
      r.th = m_th; r.tl = m_tl; r.w = m_win; r.l = m_lose;
      r.tries = m_tries; r.sec = m_seco;
      sb.push_back(r);
   endtask

   task automatic compare_outputs(input string tag);
      res_t r;
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL %s: scoreboard empty, observed none expected entry", tag);
      end else begin
         n_cmp--;
         r = sb.pop_front();
         check({tag, ".too_high"},   8'(too_high),   8'(r.th));
         check({tag, ".too_low"},    8'(too_low),    8'(r.tl));
         check({tag, ".win"},        8'(win),        8'(r.w));
         check({tag, ".lose"},       8'(lose),       8'(r.l));
         check({tag, ".tries_left"}, 8'(tries_left), 8'(r.tries));
         check({tag, ".secret_o"},   8'(secret_o),   8'(r.sec));
      end
   endtask

   task automatic model_guess(input logic [2:0] g);
      if (m_play) begin
         if (g == m_secret) begin
            m_win = 1'b1; m_th = 1'b0; m_tl = 1'b0;
            m_play = 1'b0; m_seco = m_secret;
         end else begin
            m_tries = m_tries - 3'd1;
            m_th = (g > m_secret);
            m_tl = (g < m_secret);
            if (m_tries == 3'd0) begin
               m_lose = 1'b1; m_play = 1'b0; m_seco = m_secret;
            end
         end
      end
   endtask

   task automatic model_start(input logic fe, input logic [2:0] fv);
      m_secret = fe ? fv : m_lfsr[2:0];
      m_play = 1'b1; m_tries = 3'd4;
      m_th = 1'b0; m_tl = 1'b0; m_win = 1'b0; m_lose = 1'b0; m_seco = 3'd0;
   endtask

   // Start a game; results compared once PLAY has been entered.
   task automatic start_game(input logic fe, input logic [2:0] fv, input string tag);
      @(negedge clk);
      start = 1'b1; force_en = fe; force_val = fv;
      @(negedge clk);                  // start sampled; LFSR value now in use
      model_start(fe, fv);
      push_expect();
      start = 1'b0; force_en = 1'b0;
      @(negedge clk);
      compare_outputs(tag);
   endtask

   // One submit press; result compared two edges after it is first sampled.
   task automatic press(input logic [2:0] g, input string tag);
      @(negedge clk);
      submit = 1'b1; guess = g;
      model_guess(g);
      push_expect();
      @(negedge clk);
      submit = 1'b0;
      @(negedge clk);
      @(negedge clk);
      compare_outputs(tag);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; submit = 1'b0; guess = 3'd0;
      force_en = 1'b0; force_val = 3'd0;
      model_reset();

      // 1. Reset
      repeat (2) @(negedge clk);
      push_expect();
      compare_outputs("reset");
      check("reset.state", 8'(dut.state_q), 8'(IDLE));
      reset = 1'b0;

      // Submit in IDLE is ignored
      press(3'd3, "idle_submit");
      check("idle.state", 8'(dut.state_q), 8'(IDLE));

      // 2. Forced secret 5: low, high, win
      start_game(1'b1, 3'd5, "g5.start");
      press(3'd2, "g5.guess2");
      press(3'd7, "g5.guess7");
      press(3'd5, "g5.guess5");

      // 3. Forced secret 0: four high guesses -> lose, then a fifth press
      start_game(1'b1, 3'd0, "g0.start");
      press(3'd1, "g0.guess1");
      press(3'd2, "g0.guess2");
      press(3'd3, "g0.guess3");
      press(3'd4, "g0.guess4");
      press(3'd6, "g0.guess5th");
      check("g0.state", 8'(dut.state_q), 8'(LOST));

      // 4. Forced secret 3; submit held for 10 cycles with guess 6
      start_game(1'b1, 3'd3, "g3.start");
      @(negedge clk);
      submit = 1'b1; guess = 3'd6;
      model_guess(3'd6);
      @(negedge clk);                  // first high sample (edge N)
      @(negedge clk);                  // edge N+1: still in CHECK
      check("hold.early_tries", 8'(tries_left), 8'd4);
      push_expect();
      @(negedge clk);                  // edge N+2: result visible
      compare_outputs("hold.result");
      repeat (7) @(negedge clk);
      submit = 1'b0;
      push_expect();
      repeat (3) @(negedge clk);
      compare_outputs("hold.after");

      // 5a. Simultaneous start and submit with tries_left=2
      start_game(1'b1, 3'd2, "sim.start");
      press(3'd0, "sim.guess0");
      press(3'd7, "sim.guess7");
      @(negedge clk);
      start = 1'b1; submit = 1'b1; force_en = 1'b1; force_val = 3'd2; guess = 3'd1;
      @(negedge clk);
      model_start(1'b1, 3'd2);
      push_expect();
      start = 1'b0; force_en = 1'b0;
      @(negedge clk);
      compare_outputs("sim.both");
      check("sim.state", 8'(dut.state_q), 8'(PLAY));
      submit = 1'b0;
      push_expect();
      repeat (4) @(negedge clk);
      compare_outputs("sim.settle");

      // 5b. Reset during CHECK
      start_game(1'b1, 3'd3, "rc.start");
      @(negedge clk);
      submit = 1'b1; guess = 3'd1;
      @(negedge clk);
      submit = 1'b0;
      @(negedge clk);
      check("rc.in_check", 8'(dut.state_q), 8'(CHECK));
      reset = 1'b1;
      model_reset();
      push_expect();
      @(negedge clk);
      compare_outputs("rc.reset");
      check("rc.state", 8'(dut.state_q), 8'(IDLE));
      reset = 1'b0;

      // 6. LFSR-drawn secrets across three games
      for (int k = 0; k < 3; k++) begin
         repeat (5 + 7 * k) @(negedge clk);
         start_game(1'b0, 3'd0, "rnd.start");
         press(m_secret ^ 3'd1, "rnd.miss");
         if (k < 2) begin
            press(m_secret, "rnd.win");
         end else begin
            press(m_secret ^ 3'd2, "rnd.miss2");
            press(m_secret ^ 3'd4, "rnd.miss3");
            press(m_secret ^ 3'd7, "rnd.lose");
         end
      end

      // LFSR tracks the reference and never reads 0
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         check("lfsr.value", dut.u_lfsr.q, m_lfsr);
         check("lfsr.nonzero", 8'(dut.u_lfsr.q != 8'h00), 8'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_guess_game_ctrl
